coeff_runlevel_scan: RTL and testbench

- Downstream consumer of the 4x4 forward-quantize stage; feeds the CAVLC entropy coder.
- Accepts one block of 16 quantized coefficients in raster order and reorders it by frame zigzag.
- Walks the block in reverse scan order; emits (level, run_before) pairs serially over a valid/ready handshake.
- Reports the per-block CAVLC summary: TotalCoeff, TrailingOnes, TotalZeros.

---
 rtl/coeff_runlevel_scan_pkg.sv | 18 +
 rtl/zigzag_reorder_4x4.sv | 16 +
 rtl/coeff_runlevel_scan.sv | 184 ++++++++++++++++++
 tb/tb_coeff_runlevel_scan.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/coeff_runlevel_scan_pkg.sv
// Shared transform/entropy definitions: 4x4 frame zigzag order, scan FSM states
// and the CAVLC run/count widths.
package coeff_runlevel_scan_pkg;

  localparam int TOTAL_COEFF_W = 5;
  localparam int RUN_W         = 4;

  // Raster index (4*row+col) visited at each scan position 0..15.
  localparam logic [3:0] ZIGZAG_4x4 [16] = '{
    4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
    4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
  };

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_e;

  typedef logic [RUN_W-1:0] run_t;

endpackage

// File: rtl/zigzag_reorder_4x4.sv
// Combinational raster-to-scan permutation of a 4x4 block; pure wiring, so it
// can be reused for the inverse scan on the decoder side.
module zigzag_reorder_4x4
  import coeff_runlevel_scan_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [15:0][W-1:0] raster_i,
  output logic [15:0][W-1:0] scan_o
);

  for (genvar k = 0; k < 16; k++) begin : g_scan
    assign scan_o[k] = raster_i[ZIGZAG_4x4[k]];
  end

endmodule

// File: rtl/coeff_runlevel_scan.sv
// Zigzag-reorders a 4x4 quantized block, walks it from the highest scan position
// down, and streams (level, run_before) pairs plus the CAVLC block summary.
module coeff_runlevel_scan
  import coeff_runlevel_scan_pkg::*;
#(
  parameter int BIT_LENGTH = 31
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [15:0][BIT_LENGTH:0] coeffs_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic signed [BIT_LENGTH:0] out_level_o,
  output logic [RUN_W-1:0]          out_run_o,
  output logic                      out_last_o,
  output logic                      sum_valid_o,
  output logic [TOTAL_COEFF_W-1:0]  total_coeff_o,
  output logic [1:0]                trailing_ones_o,
  output logic [3:0]                total_zeros_o,
  output logic                      busy_o
);

  typedef struct packed {
    logic signed [BIT_LENGTH:0] level;
    run_t                       run;
  } pair_t;

  localparam logic [TOTAL_COEFF_W-1:0] ONE_TC = TOTAL_COEFF_W'(1);
  localparam logic [BIT_LENGTH:0]      LVL_P1 = {{BIT_LENGTH{1'b0}}, 1'b1};
  localparam logic [BIT_LENGTH:0]      LVL_M1 = '1;

  logic [15:0][BIT_LENGTH:0] z_scan;

  zigzag_reorder_4x4 #(.W(BIT_LENGTH + 1)) u_zigzag (
    .raster_i (coeffs_i),
    .scan_o   (z_scan)
  );

  state_e                    state_q, state_d;
  logic [3:0]                idx_q, idx_d;
  logic [15:0][BIT_LENGTH:0] z_q, z_d;
  pair_t                     pbuf_q [16];
  pair_t                     pbuf_d [16];
  logic [3:0]                rd_q, rd_d;
  logic                      pend_vld_q, pend_vld_d;
  pair_t                     pend_q, pend_d;
  logic [TOTAL_COEFF_W-1:0]  tc_q, tc_d;
  logic [1:0]                t1_q, t1_d;
  logic                      t1_stop_q, t1_stop_d;
  logic [3:0]                tz_q, tz_d;
  logic                      sum_valid_q, sum_valid_d;

  logic signed [BIT_LENGTH:0] cur;
  logic                       nz, mag_one, last;
  logic [TOTAL_COEFF_W-1:0]   w;
  pair_t                      np;
  logic                       np_vld;

  assign cur     = z_q[idx_q];
  assign nz      = (cur != '0);
  assign mag_one = (cur == LVL_P1) || (cur == LVL_M1);
  assign last    = ({1'b0, rd_q} == (tc_q - ONE_TC));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    z_d         = z_q;
    pbuf_d      = pbuf_q;
    rd_d        = rd_q;
    pend_vld_d  = pend_vld_q;
    pend_d      = pend_q;
    tc_d        = tc_q;
    t1_d        = t1_q;
    t1_stop_d   = t1_stop_q;
    tz_d        = tz_q;
    sum_valid_d = 1'b0;
    w           = tc_q;
    np          = pend_q;
    np_vld      = pend_vld_q;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          z_d        = z_scan;
          idx_d      = 4'd15;
          rd_d       = '0;
          pend_vld_d = 1'b0;
          pend_d     = '0;
          tc_d       = '0;
          t1_d       = '0;
          t1_stop_d  = 1'b0;
          tz_d       = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (nz) begin
          if (pend_vld_q) begin
            pbuf_d[w[3:0]] = pend_q;
            w              = w + ONE_TC;
          end
          np.level = cur;
          np.run   = '0;
          np_vld   = 1'b1;
          if (!t1_stop_q) begin
            if (!mag_one)         t1_stop_d = 1'b1;
            else if (t1_q != 2'd3) t1_d     = t1_q + 2'd1;
          end
        end else if (pend_vld_q) begin
          np.run = pend_q.run + run_t'(1);
          tz_d   = tz_q + 4'd1;
        end
        // Scan position 0 can retire two entries at once: the older pending
        // one and the entry that position 0 itself opens or extends.
        if (idx_q == 4'd0) begin
          if (np_vld) begin
            pbuf_d[w[3:0]] = np;
            w              = w + ONE_TC;
          end
          pend_vld_d  = 1'b0;
          pend_d      = '0;
          sum_valid_d = 1'b1;
          state_d     = (w == '0) ? IDLE : EMIT;
        end else begin
          pend_vld_d = np_vld;
          pend_d     = np;
          idx_d      = idx_q - 4'd1;
        end
        tc_d = w;
      end
      EMIT: begin
        if (out_ready_i) begin
          if (last) state_d = IDLE;
          else      rd_d    = rd_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      z_q         <= '0;
      for (int i = 0; i < 16; i++) pbuf_q[i] <= '0;
      rd_q        <= '0;
      pend_vld_q  <= 1'b0;
      pend_q      <= '0;
      tc_q        <= '0;
      t1_q        <= '0;
      t1_stop_q   <= 1'b0;
      tz_q        <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      z_q         <= z_d;
      pbuf_q      <= pbuf_d;
      rd_q        <= rd_d;
      pend_vld_q  <= pend_vld_d;
      pend_q      <= pend_d;
      tc_q        <= tc_d;
      t1_q        <= t1_d;
      t1_stop_q   <= t1_stop_d;
      tz_q        <= tz_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign in_ready_o      = (state_q == IDLE);
  assign busy_o          = (state_q != IDLE);
  assign out_valid_o     = (state_q == EMIT);
  assign out_level_o     = out_valid_o ? pbuf_q[rd_q].level : '0;
  assign out_run_o       = out_valid_o ? pbuf_q[rd_q].run : '0;
  assign out_last_o      = out_valid_o && last;
  assign sum_valid_o     = sum_valid_q;
  assign total_coeff_o   = tc_q;
  assign trailing_ones_o = t1_q;
  assign total_zeros_o   = tz_q;

endmodule

// File: tb/tb_coeff_runlevel_scan.sv
// Directed and random blocks against a list-based CAVLC reference model.
module tb_coeff_runlevel_scan;

  localparam int BL = 31;
  localparam int ZZ [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, out_last, sum_valid, busy;
  logic [15:0][BL:0] coeffs;
  logic signed [BL:0] out_level;
  logic [3:0] out_run, total_zeros;
  logic [4:0] total_coeff;
  logic [1:0] trailing_ones;

  int total = 0, bad = 0;
  int blk [16];
  int exp_lvl [16];
  int exp_run [16];
  int exp_n, exp_t1, exp_tz;

  always #5 clk = ~clk;

  coeff_runlevel_scan #(.BIT_LENGTH(BL)) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .coeffs_i(coeffs),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_level_o(out_level), .out_run_o(out_run), .out_last_o(out_last),
    .sum_valid_o(sum_valid), .total_coeff_o(total_coeff),
    .trailing_ones_o(trailing_ones), .total_zeros_o(total_zeros), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference: list of nonzero scan positions from high to low; each run is the
  // gap to the next lower nonzero (or to position 0 for the lowest one).
  task automatic model();
    int z [16];
    int prev, top;
    for (int k = 0; k < 16; k++) z[k] = blk[ZZ[k]];
    exp_n = 0; exp_t1 = 0; exp_tz = 0; prev = -1; top = -1;
    for (int p = 15; p >= 0; p--) begin
      if (z[p] != 0) begin
        if (exp_n == 0) top = p;
        else exp_run[exp_n-1] = prev - p - 1;
        exp_lvl[exp_n] = z[p];
        prev = p;
        exp_n++;
      end
    end
    if (exp_n > 0) exp_run[exp_n-1] = prev;
    for (int p = 0; p < top; p++) if (z[p] == 0) exp_tz++;
    for (int i = 0; i < exp_n && exp_t1 < 3; i++) begin
      if (exp_lvl[i] == 1 || exp_lvl[i] == -1) exp_t1++;
      else break;
    end
  endtask

  task automatic load_coeffs();
    for (int k = 0; k < 16; k++) coeffs[k] = blk[k];
  endtask

  task automatic send();
    int cnt;
    load_coeffs();
    in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("accept_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // mode 0: always ready; 1: stall 3 cycles on the third pair; 2: random stalls.
  task automatic run_checks(input int mode, input int max_pairs);
    int k, cyc, stalls;
    bit stall;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i < 16) begin
        chk("scan_sum_valid", sum_valid, 0);
        chk("scan_in_ready", in_ready, 0);
        chk("scan_busy", busy, 1);
        chk("scan_out_valid", out_valid, 0);
      end
    end
    chk("sum_valid", sum_valid, 1);
    chk("total_coeff", total_coeff, exp_n);
    chk("trailing_ones", trailing_ones, exp_t1);
    chk("total_zeros", total_zeros, exp_tz);
    chk("sum_out_valid", out_valid, exp_n != 0);
    chk("sum_in_ready", in_ready, exp_n == 0);
    if (exp_n == 0) begin
      @(posedge clk); #1;
      chk("empty_sum_pulse", sum_valid, 0);
      chk("empty_out_valid", out_valid, 0);
      return;
    end
    k = 0; cyc = 0; stalls = 0;
    while (k < exp_n && k < max_pairs && cyc < 400) begin
      case (mode)
        1:       stall = (k == 2 && stalls < 3);
        2:       stall = ($urandom_range(0, 3) == 0);
        default: stall = 1'b0;
      endcase
      out_ready = !stall;
      chk("pair_valid", out_valid, 1);
      chk("pair_level", out_level, exp_lvl[k]);
      chk("pair_run", out_run, exp_run[k]);
      chk("pair_last", out_last, k == exp_n - 1);
      @(posedge clk); #1;
      chk("sum_pulse_width", sum_valid, 0);
      chk("hold_totals", total_coeff, exp_n);
      if (stall) stalls++;
      else k++;
      cyc++;
    end
    out_ready = 1'b1;
    if (cyc >= 400) chk("emit_timeout", cyc, 0);
    if (k == exp_n) begin
      chk("done_out_valid", out_valid, 0);
      chk("done_busy", busy, 0);
      chk("done_in_ready", in_ready, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; coeffs = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum_valid", sum_valid, 0);
    chk("rst_total_coeff", total_coeff, 0);
    chk("rst_trailing_ones", trailing_ones, 0);
    chk("rst_total_zeros", total_zeros, 0);
    chk("rst_out_level", out_level, 0);
    chk("rst_out_run", out_run, 0);
    chk("rst_out_last", out_last, 0);
    reset = 1'b0;

    // All-zero block
    for (int k = 0; k < 16; k++) blk[k] = 0;
    model(); send(); run_checks(0, 16);

    // Mixed block, always ready, then with a 3-cycle stall on the third pair
    blk = '{0, 3, -1, 0, 0, -1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    model(); send(); run_checks(0, 16);
    model(); send(); run_checks(1, 16);

    // Lone coefficient in the last raster slot
    for (int k = 0; k < 16; k++) blk[k] = 0;
    blk[15] = -7;
    model(); send(); run_checks(0, 16);

    // Second block offered during SCAN is held off until IDLE
    blk = '{0, 3, -1, 0, 0, -1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    model(); send();
    for (int k = 0; k < 16; k++) blk[k] = 0;
    blk[0] = 5; blk[5] = -1; blk[11] = 2;
    load_coeffs();
    in_valid = 1'b1;
    run_checks(0, 16);
    @(posedge clk); #1;
    in_valid = 1'b0;
    model(); run_checks(0, 16);

    // Reset in the middle of EMIT
    blk = '{0, 3, -1, 0, 0, -1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    model(); send(); run_checks(0, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_sum_valid", sum_valid, 0);
    chk("midrst_total_coeff", total_coeff, 0);
    for (int k = 0; k < 16; k++) blk[k] = 1;
    model(); send(); run_checks(0, 16);

    // Random blocks with random back-pressure
    for (int b = 0; b < 20; b++) begin
      for (int k = 0; k < 16; k++) begin
        int r;
        r = int'($urandom_range(0, 7));
        if (r < 4)       blk[k] = 0;
        else if (r == 4) blk[k] = 1;
        else if (r == 5) blk[k] = -1;
        else             blk[k] = int'($urandom) >>> $urandom_range(0, 28);
      end
      model(); send(); run_checks(2, 16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
